mem_serdes: RTL
===============

Name: mem_serdes

Overview:
- Parametrised successor to the core's data serialiser, sitting between the bit-serial datapath (ALU, register file) and the word-wide block RAM.
- Deserialises the effective address from the ALU and, for stores, the store data from regfile port B. Checks alignment, then does one RAM access.
- For loads, extracts, extends and re-serialises the selected byte, half, word or doubleword back to the datapath.
- Generalised over data width, digit width (bits per cycle) and address width. Adds a start/busy/done handshake and sign/zero extension.

Parameters:
- D_WIDTH, 32, RAM data width. Legal values: 32 or 64.
- DIGIT, 1, bits transferred per cycle. Must divide D_WIDTH. N = D_WIDTH/DIGIT.
- ADDR_WIDTH, 10, RAM word-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = load, 1 = store; sampled with start
- func  in  3  RISC-V funct3 (0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU); sampled with start
- addr_digit  in  DIGIT  effective-address digit, LSB-first
- data_digit  in  DIGIT  store-data digit, LSB-first
- mem_rdata  in  D_WIDTH  RAM read data; valid the cycle after mem_en
- mem_en  out  1  RAM enable
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wdata  out  D_WIDTH  RAM write data
- mem_wmask  out  D_WIDTH/8  byte write enables; all-zero on a read
- load_digit  out  DIGIT  load-result digit, LSB-first
- load_valid  out  1  load_digit valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misaligned  out  1  set in DONE if the access was rejected; held until next accepted start

Behaviour:
- Reset (rst=0): state goes to IDLE immediately. All outputs 0. Shift registers and counters cleared. Any in-flight access is abandoned and no RAM write is issued after reset.
- Let OB = log2(D_WIDTH/8). Byte offset = addr[OB-1:0]. mem_addr = addr[ADDR_WIDTH+OB-1:OB].
- IDLE: on start=1, latch mode and func, clear misaligned, go to ADDR. start while busy is ignored.
- ADDR, N cycles (cycles 1..N after the start cycle 0):
  - Shift addr_digit into the address register, LSB-first.
  - Store mode: data_digit is shifted in during these same cycles.
- Legality check at the end of ADDR:
  - Illegal if size > D_WIDTH, if func=7, or if func=3 with D_WIDTH=32.
  - Illegal if a store uses func ≥ 4.
  - Illegal if addr is not size-aligned (H: bit 0; W: bits 1:0; D: bits 2:0).
  - On failure: go to DONE with misaligned=1. No mem_en is ever asserted.
- Load path:
  - MEM (cycle N+1): mem_en=1, mem_wmask=0.
  - CAPTURE (N+2): take mem_rdata >> (8·offset). Truncate to the access size, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to D_WIDTH.
  - SHIFT_OUT (N+3..2N+2): load_valid=1; drive one DIGIT per cycle, LSB-first.
  - DONE (2N+3).
- Store path:
  - WRITE (N+1): mem_en=1, mem_wdata = size-truncated data << (8·offset).
  - mem_wmask = size mask (B 1, H 3, W F, D FF) << offset. Unselected wdata bytes are 0.
  - DONE (N+2).
- DONE: done=1 for one cycle, then IDLE. A start seen in DONE is ignored; start is accepted only from the following IDLE cycle.
- load_digit is 0 whenever load_valid=0. mem_addr, mem_wdata and mem_wmask are 0 whenever mem_en=0.

Test Plan:
- D_WIDTH=32, DIGIT=1; SW, addr 0x10, data 0xDEADBEEF -> cycle 33: mem_en=1, mem_addr=4, mem_wdata=0xDEADBEEF, mem_wmask=4'hF; cycle 34: done=1, misaligned=0.
- LB, addr 0x13, RAM word 4 = 0x80FF1234 -> cycle 33 mem_en, mem_addr=4; cycles 35..66 load_valid=1 and bits form 0xFFFFFF80; done at cycle 67. Same access as LBU -> 0x00000080.
- SH, addr 0x22, data 0x1234ABCD -> mem_addr=8, mem_wdata=0xABCD0000, mem_wmask=4'b1100.
- LW, addr 0x06 -> done at cycle 33 with misaligned=1, mem_en never high. A following legal LW clears misaligned.
- Assert rst low mid-SHIFT_OUT (cycle 45) -> load_valid, busy and done drop asynchronously. After release, a fresh SW completes normally. Store variant: assert rst during ADDR -> no write is ever issued.
- DIGIT=4; LH, addr 0x2, RAM word 0 = 0x80010000 -> mem_en at cycle 9; digits (cycles 11..18) 1,0,0,8,F,F,F,F = 0xFFFF8001; done at cycle 19.

Source files
------------

// File: rtl/mem_serdes.sv
// rtl/mem_serdes.sv - digit-serial load/store bridge between the bit-serial datapath and word-wide RAM
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   start, mode, func        request (sampled in IDLE only); mode 0 load / 1 store; func = RISC-V funct3
//   addr_digit, data_digit   effective address and store data, DIGIT bits per cycle, LSB-first
//   mem_en .. mem_wmask      RAM port; read data returns on mem_rdata one cycle after mem_en
//   load_digit, load_valid   extended load result, DIGIT bits per cycle, LSB-first
//   busy, done, misaligned   status; misaligned holds until the next accepted start
module mem_serdes #(
  parameter int D_WIDTH    = 32,
  parameter int DIGIT      = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [2:0]             func,
  input  logic [DIGIT-1:0]       addr_digit,
  input  logic [DIGIT-1:0]       data_digit,
  input  logic [D_WIDTH-1:0]     mem_rdata,
  output logic                   mem_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [D_WIDTH-1:0]     mem_wdata,
  output logic [D_WIDTH/8-1:0]   mem_wmask,
  output logic [DIGIT-1:0]       load_digit,
  output logic                   load_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   misaligned
);

  localparam int N  = D_WIDTH / DIGIT;
  localparam int NB = D_WIDTH / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = ADDR_WIDTH + OB;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_MEM, S_CAPTURE, S_SHIFT, S_WRITE, S_DONE
  } state_t;

  state_t             state;
  logic               mode_q;
  logic [2:0]         func_q;
  logic [CW-1:0]      cnt;
  logic [D_WIDTH-1:0] addr_sr;
  logic [D_WIDTH-1:0] data_sr;
  logic [D_WIDTH-1:0] out_sr;

  logic [D_WIDTH-1:0] addr_nxt;
  logic [D_WIDTH-1:0] data_nxt;
  logic               illegal;
  logic [D_WIDTH-1:0] rd_shift;
  logic [D_WIDTH-1:0] rd_mask;
  logic               sign_bit;
  logic [D_WIDTH-1:0] ld_ext;
  logic [D_WIDTH-1:0] wdata_nxt;
  logic [NB-1:0]      wmask_nxt;
  logic               unused_bits;

  // Low ones covering the access size in bits.
  function automatic logic [D_WIDTH-1:0] size_mask(input logic [1:0] s);
    logic [D_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++)
      if (b < (1 << s)) m[8*b +: 8] = 8'hff;
    return m;
  endfunction

  function automatic logic [NB-1:0] byte_mask(input logic [1:0] s);
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++)
      if (b < (1 << s)) m[b] = 1'b1;
    return m;
  endfunction

  // Value the shift registers take this cycle; the legality check and the
  // RAM request both need the address including the digit arriving now.
  assign addr_nxt = {addr_digit, addr_sr[D_WIDTH-1:DIGIT]};
  assign data_nxt = {data_digit, data_sr[D_WIDTH-1:DIGIT]};

  always_comb begin
    illegal = 1'b0;
    if (func_q == 3'd7) illegal = 1'b1;
    if (func_q == 3'd3 && D_WIDTH < 64) illegal = 1'b1;
    if (mode_q && func_q[2]) illegal = 1'b1;
    case (func_q[1:0])
      2'd1:    if (addr_nxt[0]) illegal = 1'b1;
      2'd2:    if (addr_nxt[1:0] != 2'd0) illegal = 1'b1;
      2'd3:    if (addr_nxt[2:0] != 3'd0) illegal = 1'b1;
      default: ;
    endcase
  end

  // Load extraction: the top bit of the size mask selects the sign bit.
  always_comb begin
    rd_shift = mem_rdata >> {addr_sr[OB-1:0], 3'b000};
    rd_mask  = size_mask(func_q[1:0]);
    sign_bit = |(rd_shift & rd_mask & ~(rd_mask >> 1));
    ld_ext   = rd_shift & rd_mask;
    if (!func_q[2] && sign_bit) ld_ext = ld_ext | ~rd_mask;
  end

  assign wdata_nxt = (data_nxt & size_mask(func_q[1:0])) << {addr_nxt[OB-1:0], 3'b000};
  assign wmask_nxt = byte_mask(func_q[1:0]) << addr_nxt[OB-1:0];

  assign busy = (state != S_IDLE);

  // Shift-register tails and address bits above the RAM range carry no meaning.
  assign unused_bits = ^{addr_sr, data_sr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      func_q     <= 3'd0;
      cnt        <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      out_sr     <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      load_digit <= '0;
      load_valid <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            func_q     <= func;
            misaligned <= 1'b0;
            cnt        <= '0;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          addr_sr <= addr_nxt;
          if (mode_q) data_sr <= data_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            if (illegal) begin
              misaligned <= 1'b1;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              mem_en   <= 1'b1;
              mem_addr <= addr_nxt[AW-1:OB];
              if (mode_q) begin
                mem_wdata <= wdata_nxt;
                mem_wmask <= wmask_nxt;
                state     <= S_WRITE;
              end else begin
                state <= S_MEM;
              end
            end
          end
        end
        S_MEM: begin
          mem_en   <= 1'b0;
          mem_addr <= '0;
          state    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          load_digit <= ld_ext[DIGIT-1:0];
          out_sr     <= ld_ext >> DIGIT;
          load_valid <= 1'b1;
          cnt        <= '0;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            load_valid <= 1'b0;
            load_digit <= '0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            load_digit <= out_sr[DIGIT-1:0];
            out_sr     <= out_sr >> DIGIT;
          end
        end
        S_WRITE: begin
          mem_en    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wmask <= '0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
